// File: rtl/led_status_ctrl_if.sv
// ============================================================================
// Module      : led_status_ctrl_if
// Description : Config/event/LED bundle between firmware status sources and
//               the LED controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_status_ctrl_if;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_mode;
  logic [3:0] event_in;
  logic [3:0] led_n;
  logic       tick;

  modport master (
    output cfg_wr,
    output cfg_addr,
    output cfg_mode,
    output event_in,
    input  led_n,
    input  tick
  );

  modport slave (
    input  cfg_wr,
    input  cfg_addr,
    input  cfg_mode,
    input  event_in,
    output led_n,
    output tick
  );
endinterface

`default_nettype wire

// File: rtl/led_status_ctrl.sv
// ============================================================================
// Module      : led_status_ctrl
// Description : Per-LED programmable mode controller for four active-low LEDs
//               with shared 1 ms timebase, blink phases and event stretch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_status_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int SLOW_MS    = 500,
  parameter int FAST_MS    = 125,
  parameter int STRETCH_MS = 50
) (
  input wire              clk,
  input wire              rst,
  led_status_ctrl_if.slave bus
);

  localparam int c_PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_SLOW_W = (SLOW_MS  > 1) ? $clog2(SLOW_MS)  : 1;
  localparam int c_FAST_W = (FAST_MS  > 1) ? $clog2(FAST_MS)  : 1;
  localparam int c_STR_W  = $clog2(STRETCH_MS + 1);

  localparam logic [c_PRE_W-1:0]  c_PRE_MAX  = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_SLOW_W-1:0] c_SLOW_MAX = c_SLOW_W'(SLOW_MS - 1);
  localparam logic [c_FAST_W-1:0] c_FAST_MAX = c_FAST_W'(FAST_MS - 1);
  localparam logic [c_STR_W-1:0]  c_STR_LOAD = c_STR_W'(STRETCH_MS);

  localparam logic [2:0] c_MODE_OFF   = 3'd0;
  localparam logic [2:0] c_MODE_ON    = 3'd1;
  localparam logic [2:0] c_MODE_SLOW  = 3'd2;
  localparam logic [2:0] c_MODE_FAST  = 3'd3;
  localparam logic [2:0] c_MODE_EVENT = 3'd4;
  localparam logic [2:0] c_MODE_LATCH = 3'd5;

  logic [c_PRE_W-1:0]  r_pre;
  logic                r_tick;
  logic                w_wrap;
  logic [c_SLOW_W-1:0] r_slow_cnt;
  logic                r_slow_ph;
  logic [c_FAST_W-1:0] r_fast_cnt;
  logic                r_fast_ph;
  logic [3:0]          r_ev_d;
  logic [3:0]          w_rise;
  logic [3:0]          w_lit;
  logic [3:0]          r_led_n;

  // Internal timebase uses the wrap itself so phases move on the same edge tick rises.
  assign w_wrap = (r_pre == c_PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_pre  <= w_wrap ? '0 : r_pre + c_PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slow_cnt <= '0;
      r_slow_ph  <= 1'b0;
    end else if (w_wrap) begin
      if (r_slow_cnt == c_SLOW_MAX) begin
        r_slow_cnt <= '0;
        r_slow_ph  <= ~r_slow_ph;
      end else begin
        r_slow_cnt <= r_slow_cnt + c_SLOW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fast_cnt <= '0;
      r_fast_ph  <= 1'b0;
    end else if (w_wrap) begin
      if (r_fast_cnt == c_FAST_MAX) begin
        r_fast_cnt <= '0;
        r_fast_ph  <= ~r_fast_ph;
      end else begin
        r_fast_cnt <= r_fast_cnt + c_FAST_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_d <= '0;
    end else begin
      r_ev_d <= bus.event_in;
    end
  end

  assign w_rise = bus.event_in & ~r_ev_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_led
    logic [2:0]         r_mode;
    logic [c_STR_W-1:0] r_str;
    logic               r_latch;
    logic               w_wr_hit;
    logic               w_led_lit;

    assign w_wr_hit = bus.cfg_wr && (bus.cfg_addr == 2'(gi));

    // A write to this LED overrides a simultaneous rise: that is the acknowledge path.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_mode  <= (gi < 2) ? c_MODE_ON : c_MODE_OFF;
        r_str   <= '0;
        r_latch <= 1'b0;
      end else if (w_wr_hit) begin
        r_mode  <= bus.cfg_mode;
        r_str   <= '0;
        r_latch <= 1'b0;
      end else begin
        if (w_rise[gi]) begin
          r_str <= c_STR_LOAD;
        end else if (w_wrap && (r_str != '0)) begin
          r_str <= r_str - c_STR_W'(1);
        end
        if (w_rise[gi]) begin
          r_latch <= 1'b1;
        end
      end
    end

    always_comb begin
      w_led_lit = 1'b0;
      case (r_mode)
        c_MODE_OFF:   w_led_lit = 1'b0;
        c_MODE_ON:    w_led_lit = 1'b1;
        c_MODE_SLOW:  w_led_lit = r_slow_ph;
        c_MODE_FAST:  w_led_lit = r_fast_ph;
        c_MODE_EVENT: w_led_lit = (r_str != '0);
        c_MODE_LATCH: w_led_lit = r_latch;
        default:      w_led_lit = 1'b0;
      endcase
    end

    assign w_lit[gi] = w_led_lit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led_n <= 4'b1111;
    end else begin
      r_led_n <= ~w_lit;
    end
  end

  assign bus.led_n = r_led_n;
  assign bus.tick  = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
// ============================================================================
// Module      : tb_led_status_ctrl
// Description : Directed self-checking bench for led_status_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_status_ctrl;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   edge_n;

  led_status_ctrl_if bus_if ();

  led_status_ctrl #(
    .TICK_DIV   (4),
    .SLOW_MS    (4),
    .FAST_MS    (2),
    .STRETCH_MS (3)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %b expected %b", tag, edge_n, obs, exp_v);
    end
  endtask

  // Edge numbers below are counted from reset release.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic go(input int k);
    if (k > edge_n) adv(k - edge_n);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [2:0] mode);
    bus_if.cfg_wr   = 1'b1;
    bus_if.cfg_addr = addr;
    bus_if.cfg_mode = mode;
    adv(1);
    bus_if.cfg_wr   = 1'b0;
  endtask

  task automatic pulse(input int idx);
    bus_if.event_in[idx] = 1'b1;
    adv(1);
    bus_if.event_in[idx] = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    edge_n = 0;
    rst = 1'b1;
    bus_if.cfg_wr   = 1'b0;
    bus_if.cfg_addr = 2'd0;
    bus_if.cfg_mode = 3'd0;
    bus_if.event_in = 4'b0000;

    adv(3);
    check_val("rst_led", bus_if.led_n, 4'b1111);
    check_val("rst_tick", 4'(bus_if.tick), 4'd0);
    rst = 1'b0;
    edge_n = 0;

    go(1);  check_val("por_led", bus_if.led_n, 4'b1100);
    check_val("tick_r1", 4'(bus_if.tick), 4'd0);
    go(3);  check_val("tick_r3", 4'(bus_if.tick), 4'd0);
    go(4);  check_val("tick_first", 4'(bus_if.tick), 4'd1);
    go(5);  check_val("tick_drop", 4'(bus_if.tick), 4'd0);
    go(8);  check_val("tick_period", 4'(bus_if.tick), 4'd1);

    // LED2 slow, LED3 fast, written back-to-back
    cfg_write(2'd2, 3'd2);
    cfg_write(2'd3, 3'd3);
    go(11); check_val("blink_r11", bus_if.led_n, 4'b0100);
    go(16); check_val("blink_r16", bus_if.led_n, 4'b0100);
    check_val("tick_r16", 4'(bus_if.tick), 4'd1);
    go(17); check_val("blink_r17", bus_if.led_n, 4'b1000);
    go(24); check_val("blink_r24", bus_if.led_n, 4'b1000);
    go(25); check_val("blink_r25", bus_if.led_n, 4'b0000);
    go(33); check_val("blink_r33", bus_if.led_n, 4'b1100);

    // Event stretch on LED0
    cfg_write(2'd0, 3'd4);
    pulse(0);
    check_val("ev_r35", 4'(bus_if.led_n[0]), 4'd1);
    go(36); check_val("ev_lit", 4'(bus_if.led_n[0]), 4'd0);
    go(44); check_val("ev_last", 4'(bus_if.led_n[0]), 4'd0);
    go(45); check_val("ev_expire", 4'(bus_if.led_n[0]), 4'd1);
    pulse(0);
    go(47); check_val("ev2_lit", 4'(bus_if.led_n[0]), 4'd0);
    go(52);
    pulse(0);
    go(57); check_val("retrig_hold", 4'(bus_if.led_n[0]), 4'd0);
    go(64); check_val("retrig_last", 4'(bus_if.led_n[0]), 4'd0);
    go(65); check_val("retrig_expire", 4'(bus_if.led_n[0]), 4'd1);

    // Event latch on LED1
    cfg_write(2'd1, 3'd5);
    check_val("latch_wr_lat", 4'(bus_if.led_n[1]), 4'd0);
    go(67); check_val("latch_idle", 4'(bus_if.led_n[1]), 4'd1);
    pulse(1);
    check_val("latch_r68", 4'(bus_if.led_n[1]), 4'd1);
    go(69); check_val("latch_set", 4'(bus_if.led_n[1]), 4'd0);
    go(90); check_val("latch_hold", 4'(bus_if.led_n[1]), 4'd0);
    cfg_write(2'd1, 3'd5);
    check_val("ack_r91", 4'(bus_if.led_n[1]), 4'd0);
    go(92); check_val("ack_clear", 4'(bus_if.led_n[1]), 4'd1);

    // Write and rise on LED0 in the same cycle
    bus_if.event_in[0] = 1'b1;
    cfg_write(2'd0, 3'd4);
    bus_if.event_in[0] = 1'b0;
    go(94);  check_val("collide_r94", 4'(bus_if.led_n[0]), 4'd1);
    go(100); check_val("collide_r100", 4'(bus_if.led_n[0]), 4'd1);

    // Reserved mode on LED3
    cfg_write(2'd3, 3'd6);
    go(102); check_val("rsvd_r102", 4'(bus_if.led_n[3]), 4'd1);
    go(110); check_val("rsvd_r110", 4'(bus_if.led_n[3]), 4'd1);

    // Reset during active stretch and blink
    pulse(0);
    go(112); check_val("pre_rst_ev", 4'(bus_if.led_n[0]), 4'd0);
    rst = 1'b1;
    adv(2);
    check_val("mid_rst_led", bus_if.led_n, 4'b1111);
    check_val("mid_rst_tick", 4'(bus_if.tick), 4'd0);
    rst = 1'b0;
    edge_n = 0;

    go(1); check_val("rel_led", bus_if.led_n, 4'b1100);
    cfg_write(2'd2, 3'd2);
    cfg_write(2'd3, 3'd3);
    check_val("rel_phase0", bus_if.led_n, 4'b1100);
    check_val("rel_tick_r3", 4'(bus_if.tick), 4'd0);
    go(4);  check_val("rel_tick_r4", 4'(bus_if.tick), 4'd1);
    go(8);  check_val("rel_r8", bus_if.led_n, 4'b1100);
    go(9);  check_val("rel_r9", bus_if.led_n, 4'b0100);
    go(17); check_val("rel_r17", bus_if.led_n, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
